// File: rtl/rst_seq_pkg.sv
// Shared types and constants for the reset sequencer.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    STRETCH = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2,
    HOLD    = 2'd3
  } rst_seq_state_e;

  localparam int unsigned CausePorIdx = 0;

endpackage

// File: rtl/rst_req_sync.sv
// Two-flop synchroniser for asynchronous level reset requests.
module rst_req_sync #(
  parameter int unsigned Width = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] r_meta;
  logic [Width-1:0] r_sync;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= d_i;
      r_sync <= r_meta;
    end
  end

  assign q_o = r_sync;

endmodule

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: merges reset requests, stretches reset, then releases
// domains one at a time in index order; keeps a sticky reset cause.
module rst_seq_ctrl
  import rst_seq_pkg::*;
#(
  parameter int unsigned NumDomains    = 3,
  parameter int unsigned NumReqs       = 3,
  parameter int unsigned StretchCycles = 16,
  parameter int unsigned GapCycles     = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NumReqs-1:0]    rst_req_i,
  input  logic                  cause_clr_i,
  output logic [NumDomains-1:0] dom_rst_no,
  output logic                  busy_o,
  output logic [NumReqs:0]      rst_cause_o
);

  localparam int unsigned CntMax = (StretchCycles > GapCycles) ? StretchCycles : GapCycles;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam int unsigned IdxW   = (NumDomains > 1) ? $clog2(NumDomains) : 1;
  localparam int unsigned CauseW = NumReqs + 1;

  localparam logic [CntW-1:0] StretchLast = CntW'(StretchCycles - 1);
  localparam logic [CntW-1:0] GapLast     = CntW'(GapCycles - 1);
  localparam logic [IdxW-1:0] IdxLast     = IdxW'(NumDomains - 1);
  localparam logic [CauseW-1:0] CausePor  = CauseW'(1) << CausePorIdx;

  logic [NumReqs-1:0]    w_req_sync;
  logic                  w_req_any;
  logic [CauseW-1:0]     w_req_cause;

  rst_seq_state_e        r_state, w_state_d;
  logic [CntW-1:0]       r_cnt, w_cnt_d;
  logic [IdxW-1:0]       r_idx, w_idx_d;
  logic [NumDomains-1:0] r_dom, w_dom_d;
  logic [CauseW-1:0]     r_cause, w_cause_d;
  logic                  r_busy;

  rst_req_sync #(
    .Width (NumReqs)
  ) u_req_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (rst_req_i),
    .q_o    (w_req_sync)
  );

  assign w_req_any   = |w_req_sync;
  assign w_req_cause = {w_req_sync, 1'b0};

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_idx_d   = r_idx;
    w_dom_d   = r_dom;
    w_cause_d = r_cause;

    if (w_req_any) begin
      // A request pre-empts every state; a same-edge clear in RUN keeps only the new causes.
      w_state_d = HOLD;
      w_cnt_d   = '0;
      w_idx_d   = '0;
      w_dom_d   = '0;
      if (r_state == RUN && cause_clr_i) begin
        w_cause_d = w_req_cause;
      end else begin
        w_cause_d = r_cause | w_req_cause;
      end
    end else begin
      unique case (r_state)
        HOLD: begin
          w_state_d = STRETCH;
          w_cnt_d   = '0;
        end
        STRETCH: begin
          if (r_cnt == StretchLast) begin
            w_state_d  = RELEASE;
            w_cnt_d    = '0;
            w_idx_d    = '0;
            w_dom_d[0] = 1'b1;
          end else begin
            w_cnt_d = r_cnt + CntW'(1);
          end
        end
        RELEASE: begin
          if (r_cnt == GapLast) begin
            w_cnt_d = '0;
            if (r_idx == IdxLast) begin
              w_state_d = RUN;
            end else begin
              w_idx_d = r_idx + IdxW'(1);
              for (int unsigned d = 0; d < NumDomains; d++) begin
                if (d == 32'(r_idx) + 32'd1) begin
                  w_dom_d[d] = 1'b1;
                end
              end
            end
          end else begin
            w_cnt_d = r_cnt + CntW'(1);
          end
        end
        RUN: begin
          if (cause_clr_i) begin
            w_cause_d = '0;
          end
        end
        default: begin
          w_state_d = HOLD;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= STRETCH;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_dom   <= '0;
      r_cause <= CausePor;
      r_busy  <= 1'b1;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_idx   <= w_idx_d;
      r_dom   <= w_dom_d;
      r_cause <= w_cause_d;
      r_busy  <= (w_state_d != RUN);
    end
  end

  assign dom_rst_no  = r_dom;
  assign busy_o      = r_busy;
  assign rst_cause_o = r_cause;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed bench for rst_seq_ctrl with hand-computed edge timing (defaults 3/3/16/4).
module tb_rst_seq_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic [2:0] rst_req_i;
  logic       cause_clr_i;
  logic [2:0] dom_rst_no;
  logic       busy_o;
  logic [3:0] rst_cause_o;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk_i = ~clk_i;

  rst_seq_ctrl #(
    .NumDomains    (3),
    .NumReqs       (3),
    .StretchCycles (16),
    .GapCycles     (4)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .rst_req_i   (rst_req_i),
    .cause_clr_i (cause_clr_i),
    .dom_rst_no  (dom_rst_no),
    .busy_o      (busy_o),
    .rst_cause_o (rst_cause_o)
  );

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Each call advances past n rising edges; we always sit on a falling edge.
  task automatic tick(input int unsigned n);
    repeat (n) @(negedge clk_i);
  endtask

  initial begin
    rst_ni      = 1'b0;
    rst_req_i   = '0;
    cause_clr_i = 1'b0;
    tick(3);
    chk("por_dom",   8'(dom_rst_no),  8'b000);
    chk("por_busy",  8'(busy_o),      8'd1);
    chk("por_cause", 8'(rst_cause_o), 8'b0001);
    rst_ni = 1'b1;

    // POR release timing: 16, 20, 24, busy low at 28
    tick(15); chk("por_e15_dom", 8'(dom_rst_no), 8'b000);
    tick(1);  chk("por_e16_dom", 8'(dom_rst_no), 8'b001);
    tick(3);  chk("por_e19_dom", 8'(dom_rst_no), 8'b001);
    tick(1);  chk("por_e20_dom", 8'(dom_rst_no), 8'b011);
    tick(4);  chk("por_e24_dom", 8'(dom_rst_no), 8'b111);
    chk("por_e24_busy", 8'(busy_o), 8'd1);
    tick(3);  chk("por_e27_busy", 8'(busy_o), 8'd1);
    tick(1);  chk("por_e28_busy", 8'(busy_o), 8'd0);
    chk("por_run_cause", 8'(rst_cause_o), 8'b0001);

    // Request 010 held 10 cycles from RUN
    rst_req_i = 3'b010;
    tick(2);  chk("req1_n1_dom", 8'(dom_rst_no), 8'b111);
    tick(1);  chk("req1_n2_dom", 8'(dom_rst_no), 8'b000);
    chk("req1_n2_busy",  8'(busy_o),      8'd1);
    chk("req1_n2_cause", 8'(rst_cause_o), 8'b0101);
    tick(7);
    rst_req_i = '0;
    tick(18); chk("req1_m17_dom", 8'(dom_rst_no), 8'b000);
    tick(1);  chk("req1_m18_dom", 8'(dom_rst_no), 8'b001);

    // One-cycle req[0] pulse during RELEASE restarts the sequence
    rst_req_i = 3'b001;
    tick(1);
    rst_req_i = '0;
    tick(1);  chk("pulse_m20_dom", 8'(dom_rst_no), 8'b001);
    tick(1);  chk("pulse_m21_dom", 8'(dom_rst_no), 8'b000);
    chk("pulse_m21_busy",  8'(busy_o),      8'd1);
    chk("pulse_m21_cause", 8'(rst_cause_o), 8'b0111);
    tick(16); chk("pulse_m37_dom", 8'(dom_rst_no), 8'b000);
    tick(1);  chk("pulse_m38_dom", 8'(dom_rst_no), 8'b001);
    tick(4);  chk("pulse_m42_dom", 8'(dom_rst_no), 8'b011);
    tick(4);  chk("pulse_m46_dom", 8'(dom_rst_no), 8'b111);
    tick(3);  chk("pulse_m49_busy", 8'(busy_o), 8'd1);
    tick(1);  chk("pulse_m50_busy", 8'(busy_o), 8'd0);

    // Clear cause in RUN
    cause_clr_i = 1'b1;
    tick(1);
    cause_clr_i = 1'b0;
    chk("clr_run_cause", 8'(rst_cause_o), 8'b0000);

    // Simultaneous requests 101; clear ignored in HOLD; release waits for both
    rst_req_i = 3'b101;
    tick(3);
    chk("dual_dom",   8'(dom_rst_no),  8'b000);
    chk("dual_cause", 8'(rst_cause_o), 8'b1010);
    cause_clr_i = 1'b1;
    tick(1);
    cause_clr_i = 1'b0;
    chk("clr_hold_cause", 8'(rst_cause_o), 8'b1010);
    rst_req_i = 3'b100;
    tick(20);
    chk("dual_partial_dom",  8'(dom_rst_no), 8'b000);
    chk("dual_partial_busy", 8'(busy_o),     8'd1);
    rst_req_i = '0;
    tick(18); chk("dual_d17_dom", 8'(dom_rst_no), 8'b000);
    tick(1);  chk("dual_d18_dom", 8'(dom_rst_no), 8'b001);
    tick(12); chk("dual_d30_busy", 8'(busy_o), 8'd0);

    // Clear on the same edge a request acts: only the new bit survives
    rst_req_i = 3'b010;
    tick(2);
    cause_clr_i = 1'b1;
    tick(1);
    cause_clr_i = 1'b0;
    chk("clr_race_cause", 8'(rst_cause_o), 8'b0100);
    rst_req_i = '0;
    tick(31);
    chk("race_run_busy", 8'(busy_o),     8'd0);
    chk("race_run_dom",  8'(dom_rst_no), 8'b111);

    // Async rst_ni while dom=011
    rst_req_i = 3'b001;
    tick(1);
    rst_req_i = '0;
    tick(23);
    chk("mid_dom_011",   8'(dom_rst_no),  8'b011);
    chk("mid_cause_pre", 8'(rst_cause_o), 8'b0110);
    rst_ni = 1'b0;
    #1;
    chk("arst_dom",   8'(dom_rst_no),  8'b000);
    chk("arst_busy",  8'(busy_o),      8'd1);
    chk("arst_cause", 8'(rst_cause_o), 8'b0001);
    tick(1);
    rst_ni = 1'b1;
    tick(15); chk("arst_e15_dom", 8'(dom_rst_no), 8'b000);
    tick(1);  chk("arst_e16_dom", 8'(dom_rst_no), 8'b001);
    tick(11); chk("arst_e27_busy", 8'(busy_o), 8'd1);
    tick(1);  chk("arst_e28_busy", 8'(busy_o), 8'd0);
    chk("arst_e28_dom", 8'(dom_rst_no), 8'b111);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
